// File: rtl/div_pkg.sv
// Shared widths and controller state encoding for the arbitrated restoring divider.
package div_pkg;

    localparam int unsigned DEF_WN = 8;
    localparam int unsigned DEF_WD = 6;
    localparam int unsigned DEF_WR = DEF_WN + DEF_WD;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        RESTORE,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_core.sv
// Restoring-division sequencer: alternates SUB/RESTORE for WN iterations after i_start.
module div_core
    import div_pkg::*;
#(
    parameter int unsigned WN = DEF_WN,
    parameter int unsigned WD = DEF_WD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [WN-1:0] i_n,
    input  logic [WD-1:0] i_d,
    output logic          o_busy,
    output logic          o_done,
    output logic [WN-1:0] o_q,
    output logic [WD-1:0] o_r
);

    localparam int unsigned WR = WN + WD;
    localparam int unsigned WC = $clog2(WN + 1);

    div_state_e           r_state, w_state_next;
    logic signed [WR-1:0] r_rem, w_rem_next;
    logic [WR-1:0]        r_div, w_div_next;
    logic [WN-1:0]        r_q, w_q_next;
    logic [WC-1:0]        r_cnt, w_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_div   <= w_div_next;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_div_next   = r_div;
        w_q_next     = r_q;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_div_next   = {{WN{1'b0}}, i_d} << (WN - 1);
                    w_rem_next   = {{WD{1'b0}}, i_n};
                    w_q_next     = '0;
                    w_cnt_next   = '0;
                    w_state_next = SUB;
                end
            end
            SUB: begin
                w_rem_next   = r_rem - $signed(r_div);
                w_state_next = RESTORE;
            end
            RESTORE: begin
                // Negative trial remainder: undo the subtract and shift in a zero.
                if (r_rem[WR-1]) begin
                    w_rem_next = r_rem + $signed(r_div);
                    w_q_next   = {r_q[WN-2:0], 1'b0};
                end else begin
                    w_q_next   = {r_q[WN-2:0], 1'b1};
                end
                w_div_next   = r_div >> 1;
                w_cnt_next   = r_cnt + 1'b1;
                w_state_next = (r_cnt == WC'(WN - 1)) ? DONE : SUB;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_q    = r_q;
    assign o_r    = r_rem[WD-1:0];

endmodule

// File: rtl/div_arb.sv
// Two-requester round-robin front end for the shared divider, with registered results.
module div_arb
    import div_pkg::*;
#(
    parameter int unsigned WN = DEF_WN,
    parameter int unsigned WD = DEF_WD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [WN-1:0] n0_in,
    input  logic [WN-1:0] n1_in,
    input  logic [WD-1:0] d0_in,
    input  logic [WD-1:0] d1_in,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic          valid_out,
    output logic [WN-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          id_out,
    output logic          dz_out
);

    logic          r_last;  // 1: requester 1 was served last
    logic          r_id;
    logic          r_dz;
    logic          w_pick1;
    logic          w_start;
    logic          w_done;
    logic [WN-1:0] w_n;
    logic [WD-1:0] w_d;
    logic [WN-1:0] w_q;
    logic [WD-1:0] w_r;

    always_comb begin
        w_pick1 = req1 & (~req0 | ~r_last);
        w_start = ~reset & ~busy & (req0 | req1);
        gnt0    = w_start & ~w_pick1;
        gnt1    = w_start & w_pick1;
        w_n     = w_pick1 ? n1_in : n0_in;
        w_d     = w_pick1 ? d1_in : d0_in;
    end

    div_core #(
        .WN(WN),
        .WD(WD)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_start),
        .i_n    (w_n),
        .i_d    (w_d),
        .o_busy (busy),
        .o_done (w_done),
        .o_q    (w_q),
        .o_r    (w_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_dz      <= 1'b0;
            valid_out <= 1'b0;
            q_out     <= '0;
            r_out     <= '0;
            id_out    <= 1'b0;
            dz_out    <= 1'b0;
        end else begin
            if (w_start) begin
                r_last <= w_pick1;
                r_id   <= w_pick1;
                r_dz   <= (w_d == '0);
            end
            valid_out <= w_done;
            if (w_done) begin
                q_out  <= w_q;
                r_out  <= w_r;
                id_out <= r_id;
                dz_out <= r_dz;
            end
        end
    end

endmodule

// File: tb/tb_div_arb.sv
// Directed bench for div_arb: latency, arbitration, divide-by-zero, mid-run reset, extremes.
module tb_div_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] n0_in, n1_in;
    logic [5:0] d0_in, d1_in;
    logic       gnt0, gnt1, busy, valid_out, id_out, dz_out;
    logic [7:0] q_out;
    logic [5:0] r_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_arb dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .n0_in    (n0_in),
        .n1_in    (n1_in),
        .d0_in    (d0_in),
        .d1_in    (d1_in),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .valid_out(valid_out),
        .q_out    (q_out),
        .r_out    (r_out),
        .id_out   (id_out),
        .dz_out   (dz_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the grant; returns cycles since the grant cycle.
    task automatic wait_valid(output int lat);
        lat = 1;
        check_eq("busy_after_gnt", busy, 1);
        while (!valid_out && lat < 40) begin
            step();
            lat++;
        end
        check_eq("busy_at_valid", busy, 0);
    endtask

    task automatic check_res(input string tag, input int lat, input logic [7:0] eq,
                             input logic [5:0] er, input logic eid, input logic edz);
        check_eq({tag, "_lat"}, lat, 18);
        check_eq({tag, "_q"}, q_out, eq);
        check_eq({tag, "_r"}, r_out, er);
        check_eq({tag, "_id"}, id_out, eid);
        check_eq({tag, "_dz"}, dz_out, edz);
    endtask

    task automatic do_div(input string tag, input logic id, input logic [7:0] n,
                          input logic [5:0] d, input logic [7:0] eq, input logic [5:0] er,
                          input logic edz);
        int lat;
        if (id) begin
            req1 = 1'b1; n1_in = n; d1_in = d;
        end else begin
            req0 = 1'b1; n0_in = n; d0_in = d;
        end
        #1;
        check_eq({tag, "_gnt"}, {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        wait_valid(lat);
        check_res(tag, lat, eq, er, id, edz);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int lat, ng, cyc, last_cyc, nval;
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b0;
        n0_in = 8'd5; d0_in = 6'd1; n1_in = '0; d1_in = '0;
        #1;
        check_eq("rst_gnt0_forced", gnt0, 0);
        step();
        step();
        check_eq("rst_gnt0", gnt0, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_q", q_out, 0);
        check_eq("rst_r", r_out, 0);
        check_eq("rst_id", id_out, 0);
        check_eq("rst_dz", dz_out, 0);
        req0 = 1'b0;
        reset = 1'b0;
        step();

        do_div("single", 1'b0, 8'd234, 6'd50, 8'd4, 6'd34, 1'b0);

        // Tie straight after reset: requester 0 first, requester 1 back-to-back.
        apply_reset();
        req0 = 1'b1; n0_in = 8'd100; d0_in = 6'd7;
        req1 = 1'b1; n1_in = 8'd255; d1_in = 6'd63;
        #1;
        check_eq("tie_gnt", {30'd0, gnt1, gnt0}, 1);
        step();
        req0 = 1'b0;
        wait_valid(lat);
        check_res("tie0", lat, 8'd14, 6'd2, 1'b0, 1'b0);
        check_eq("tie_gnt1_b2b", {30'd0, gnt1, gnt0}, 2);
        step();
        req1 = 1'b0;
        wait_valid(lat);
        check_res("tie1", lat, 8'd4, 6'd3, 1'b1, 1'b0);
        step();

        // Both held: grants alternate, one every 18 cycles.
        req0 = 1'b1; n0_in = 8'd200; d0_in = 6'd9;
        req1 = 1'b1; n1_in = 8'd50;  d1_in = 6'd60;
        ng = 0; cyc = 0; last_cyc = 0;
        while (ng < 6 && cyc < 200) begin
            #1;
            if (gnt0 || gnt1) begin
                check_eq("rr_both", {31'd0, gnt0 & gnt1}, 0);
                check_eq("rr_who", gnt1, ng % 2);
                if (ng > 0) check_eq("rr_gap", cyc - last_cyc, 18);
                last_cyc = cyc;
                ng++;
            end
            step();
            cyc++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("rr_count", ng, 6);
        lat = 0;
        while (!valid_out && lat < 40) begin
            step();
            lat++;
        end
        check_eq("rr_last_q", q_out, 0);
        check_eq("rr_last_r", r_out, 50);
        check_eq("rr_last_id", id_out, 1);
        step();

        do_div("dz", 1'b1, 8'd77, 6'd0, 8'd255, 6'd13, 1'b1);
        step();

        // Reset asserted in cycle k+9 aborts the division silently.
        req0 = 1'b1; n0_in = 8'd200; d0_in = 6'd9;
        #1;
        check_eq("mid_gnt", gnt0, 1);
        step();
        req0 = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_valid", valid_out, 0);
        check_eq("mid_q", q_out, 0);
        check_eq("mid_r", r_out, 0);
        check_eq("mid_id", id_out, 0);
        check_eq("mid_dz", dz_out, 0);
        nval = 0;
        repeat (20) begin
            step();
            if (valid_out) nval++;
        end
        check_eq("mid_no_valid", nval, 0);
        do_div("post_rst", 1'b0, 8'd10, 6'd3, 8'd3, 6'd1, 1'b0);
        step();

        do_div("n0_d1", 1'b0, 8'd0, 6'd1, 8'd0, 6'd0, 1'b0);
        do_div("n255_d1", 1'b1, 8'd255, 6'd1, 8'd255, 6'd0, 1'b0);
        do_div("n62_d63", 1'b0, 8'd62, 6'd63, 8'd0, 6'd62, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_arb.md
# div_arb

Shared restoring-divider controller that arbitrates two requesters onto one unsigned 8-bit / 6-bit restoring-division datapath. It sequences the subtract/restore iterations and returns quotient, remainder, requester tag and divide-by-zero flag. It sits between client FSMs (e.g. two filter/normalisation channels) and the divider, so one divider serves both with deterministic latency.

## Interface

- WN, 8, numerator and quotient width
- WD, 6, denominator and remainder width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  division request, held high until granted
- n0_in, n1_in  in  WN each  numerator of requester 0/1, stable while reqX high
- d0_in, d1_in  in  WD each  denominator of requester 0/1, stable while reqX high
- gnt0, gnt1  out  1 each  grant; operands of that requester sampled on the same edge
- busy  out  1  division in progress (any state other than IDLE)
- valid_out  out  1  one-cycle pulse: q_out/r_out/id_out/dz_out valid
- q_out  out  WN  quotient
- r_out  out  WD  remainder
- id_out  out  1  requester that owns the result
- dz_out  out  1  denominator was zero

## Operation

- FSM states: IDLE, SUB, RESTORE, DONE.
- IDLE: if any reqX, grant exactly one, latch its operands, then go to SUB. Otherwise stay.
- Latched operands: d = dX_in << (WN-1), zero-extended to WN+WD bits. r = nX_in, signed, WN+WD bits. q = 0. count = 0.
- SUB: r <= r - d, then go to RESTORE.
- RESTORE:
  - If r < 0: r <= r + d and q <= q << 1.
  - Else: q <= (q << 1) | 1.
  - Then d >>= 1 and count++. Go to DONE after the WN-th iteration, else back to SUB.
- DONE: register q_out = q, r_out = r[WD-1:0], id_out, dz_out. Set valid_out for the next cycle. Go to IDLE.
- Arbitration is round-robin with a last-served pointer.
  - Only one request pending: grant it.
  - Both pending: grant the one not last served.
  - Pointer resets to "1 served", so requester 0 wins the first tie.
- gnt is combinational from state==IDLE and the reqs. It is never high outside IDLE and never both high. gnt is forced low while reset is high.
- A req dropped before grant is ignored; nothing is queued.
- d = 0: no early exit, same latency. Result is q = all ones, r = n[WD-1:0], dz_out = 1.
- The true remainder is always < d ≤ 2^WD-1, so the r truncation is lossless when d ≠ 0.
- Reset mid-operation: the next edge aborts the division, with no valid pulse for it. Pointer and all outputs return to reset values.
- Reset values: gnt0 = gnt1 = 0, busy = 0, valid_out = 0, q_out = 0, r_out = 0, id_out = 0, dz_out = 0.
- q_out, r_out, id_out and dz_out hold their last result until the next DONE.

## Timing

- Grant in cycle k (IDLE).
- SUB/RESTORE alternate in cycles k+1 … k+2·WN (k+16 at defaults).
- DONE in cycle k+2·WN+1.
- valid_out high in cycle k+2·WN+2 (k+18), state back in IDLE.
- A new grant may occur in the same cycle as valid_out, giving back-to-back throughput of one division per 18 cycles.
- busy is high from cycle k+1 through cycle k+17 inclusive.

## Structure

- Package div_pkg holds:
  - WN and WD defaults
  - the state enum (IDLE/SUB/RESTORE/DONE)
  - derived width WN+WD
- Sub-module div_core holds the SUB/RESTORE datapath and iteration counter, with a start/done handshake.
- div_arb holds the round-robin arbiter, operand mux, grant logic and output registers.

## Test plan

- Single request: req0 with n = 234, d = 50 → gnt0 at k, valid_out at k+18, q_out = 4, r_out = 34, id_out = 0, dz_out = 0.
- Tie after reset: req0 (n = 100, d = 7) and req1 (n = 255, d = 63) both high.
  - Requester 0 is granted first: q = 14, r = 2, id = 0 at k+18.
  - gnt1 comes at k+18. Its result q = 4, r = 3, id = 1 arrives at k+36.
- Round-robin: req0 and req1 both held high for 6 divisions → grants alternate 0,1,0,1,0,1. Never two consecutive grants to one requester.
- Divide by zero: req1 with n = 77, d = 0 → latency 18, q_out = 255, r_out = 13, dz_out = 1, id_out = 1.
- Reset mid-division: assert reset at k+9 for one cycle.
  - No valid_out appears.
  - busy = 0 and all outputs are 0 after the reset edge.
  - A new req0 (n = 10, d = 3) then completes 18 cycles after its grant with q = 3, r = 1.
- Extremes:
  - n = 0, d = 1 → q = 0, r = 0.
  - n = 255, d = 1 → q = 255, r = 0.
  - n = 62, d = 63 → q = 0, r = 62.
